mips_decode_issue: RTL and testbench
====================================

Name: mips_decode_issue

Overview:
- Decode and issue stage that feeds the integer ALU.
- Accepts 32-bit MIPS instruction words over a valid/ready handshake, decodes them into an ALU op select, register addresses, raw immediate and shift amount, and holds the result in a single registered output slot with valid/ready handshake.
- Keeps a 32-entry register busy scoreboard, set on issue and cleared by a writeback port, and stalls read-after-write hazards.

Parameters:
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction word present.
- in_ready  output  1  stage accepts in_instr this cycle.
- in_instr  input  32  instruction word.
- out_valid  output  1  decoded op held in the output slot.
- out_ready  input  1  ALU/execute consumes the slot.
- out_alu_op  output  4  0 ADD, 1 ADDI, 2 ADDIU, 3 ADDU, 4 SUB, 5 SUBU, 6 AND, 7 ANDI, 8 OR, 9 ORI, 10 SLL, 11 SRL, 12 SLT, 13 SLTI, 15 ILLEGAL.
- out_rs  output  5  source A register (SLL/SRL: the rt field).
- out_rt  output  5  source B register.
- out_dst  output  5  destination register (rd for R-type, rt for I-type).
- out_wen  output  1  result is written back.
- out_imm  output  16  instr[15:0], raw. The ALU performs sign extension.
- out_sa  output  16  {11'b0, instr[10:6]}.
- out_illegal  output  1  unsupported encoding.
- wb_valid  input  1  writeback complete.
- wb_addr  input  5  register written back.
- stall_count  output  CNT_W  cycles stalled by a hazard.
- issue_count  output  CNT_W  instructions accepted.

Behaviour:
- Decode (combinational on in_instr):
  - opcode 0x00, funct: 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU, 0x24 AND, 0x25 OR, 0x2A SLT, 0x00 SLL, 0x02 SRL.
  - opcode 0x08 ADDI, 0x09 ADDIU, 0x0A SLTI, 0x0C ANDI, 0x0D ORI.
  - Anything else is ILLEGAL.
- Source reads:
  - R-type ADD/ADDU/SUB/SUBU/AND/OR/SLT read rs and rt.
  - SLL/SRL read rt only; rt is driven on out_rs, and out_rt = 0.
  - I-type reads rs only.
  - ILLEGAL reads nothing.
- hazard = (reads A && busy[A]) || (reads B && busy[B]). busy[0] is always 0.
  - Busy bits are sampled registered only. There is no writeback bypass, so an instruction unblocks the cycle after wb_valid.
- in_ready = (!out_valid || out_ready) && !hazard. With in_valid = 0, in_ready still reflects slot and hazard state for the current in_instr.
- Accept = in_valid && in_ready. On accept, at the next edge:
  - all out_* fields load and out_valid = 1;
  - busy[dst] is set if out_wen && dst != 0;
  - issue_count increments, saturating at all-ones.
- Output slot:
  - If out_valid && out_ready && !accept, then out_valid = 0.
  - While out_valid && !out_ready, all out_* fields hold stable.
  - Back-to-back issue at 1 instruction/cycle when there are no hazards and out_ready = 1.
- out_wen = 1 for every legal op. For ILLEGAL: out_wen = 0, out_illegal = 1, out_alu_op = 15, and the instruction still passes through the handshake.
- Writeback: wb_valid && wb_addr != 0 clears busy[wb_addr]. wb_addr = 0 is ignored.
  - If issue sets and writeback clears the same register in the same cycle, the set wins.
  - A writeback to a non-busy register is a no-op.
- stall_count increments each cycle with in_valid && hazard, saturating. Output-slot backpressure alone is not counted.
- Reset: out_valid = 0; all out_* fields = 0; in_ready follows its equation with empty busy bits; busy = 0; both counters = 0.
  - Reset mid-operation discards the held instruction and all pending busy bits.

Test Plan:
- Reset, then 0x00221820 (ADD $3,$1,$2) with out_ready = 1 -> next cycle out_valid = 1, alu_op = 0, rs = 1, rt = 2, dst = 3, wen = 1; busy[3] = 1; issue_count = 1.
- Next 0x2065FFFF (ADDI $5,$3,-1) -> in_ready = 0 and stall_count increments each cycle. Pulse wb_valid with wb_addr = 3 -> accepted one cycle later with alu_op = 1, rs = 3, dst = 5, imm = 0xFFFF.
- 0x00022140 (SLL $4,$2,5) -> alu_op = 10, out_rs = 2, out_rt = 0, dst = 4, sa = 0x0005.
- 0xFC000000 -> out_illegal = 1, alu_op = 15, wen = 0; no busy bit set; issue_count increments.
- Hold out_ready = 0 with in_valid = 1 and independent instructions -> one instruction is captured, out_* is stable for 5 cycles, and in_ready = 0. Release -> back-to-back issue at 1 per cycle.
- ADD $0,$1,$2 (0x00220020) then an instruction reading $0 -> no stall. Then assert rst with out_valid = 1 and busy bits set -> out_valid = 0, busy cleared, and counters = 0 next cycle.

Source files
------------

// File: rtl/mips_decode_issue.sv
// Decode/issue stage for the integer ALU: decodes MIPS words, tracks register
// busy bits for RAW hazards and holds one decoded op in a valid/ready output slot.
module mips_decode_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_op,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_dst,
  output logic             out_wen,
  output logic [15:0]      out_imm,
  output logic [15:0]      out_sa,
  output logic             out_illegal,
  input  logic             wb_valid,
  input  logic [4:0]       wb_addr,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] issue_count
);

  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_ADDI    = 4'd1;
  localparam logic [3:0] OP_ADDIU   = 4'd2;
  localparam logic [3:0] OP_ADDU    = 4'd3;
  localparam logic [3:0] OP_SUB     = 4'd4;
  localparam logic [3:0] OP_SUBU    = 4'd5;
  localparam logic [3:0] OP_AND     = 4'd6;
  localparam logic [3:0] OP_ANDI    = 4'd7;
  localparam logic [3:0] OP_OR      = 4'd8;
  localparam logic [3:0] OP_ORI     = 4'd9;
  localparam logic [3:0] OP_SLL     = 4'd10;
  localparam logic [3:0] OP_SRL     = 4'd11;
  localparam logic [3:0] OP_SLT     = 4'd12;
  localparam logic [3:0] OP_SLTI    = 4'd13;
  localparam logic [3:0] OP_ILLEGAL = 4'd15;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] f_rs;
  logic [4:0] f_rt;
  logic [4:0] f_rd;

  assign opcode = in_instr[31:26];
  assign f_rs   = in_instr[25:21];
  assign f_rt   = in_instr[20:16];
  assign f_rd   = in_instr[15:11];
  assign funct  = in_instr[5:0];

  logic [3:0] dec_op;
  logic [4:0] dec_rs;
  logic [4:0] dec_rt;
  logic [4:0] dec_dst;
  logic       dec_illegal;
  logic       dec_wen;
  logic       reads_a;
  logic       reads_b;
  logic       is_rtype;
  logic       is_shift;
  logic       is_itype;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    dec_op   = OP_ILLEGAL;
    is_rtype = 1'b0;
    is_shift = 1'b0;
    is_itype = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin dec_op = OP_ADD;  is_rtype = 1'b1; end
          6'h21: begin dec_op = OP_ADDU; is_rtype = 1'b1; end
          6'h22: begin dec_op = OP_SUB;  is_rtype = 1'b1; end
          6'h23: begin dec_op = OP_SUBU; is_rtype = 1'b1; end
          6'h24: begin dec_op = OP_AND;  is_rtype = 1'b1; end
          6'h25: begin dec_op = OP_OR;   is_rtype = 1'b1; end
          6'h2A: begin dec_op = OP_SLT;  is_rtype = 1'b1; end
          6'h00: begin dec_op = OP_SLL;  is_shift = 1'b1; end
          6'h02: begin dec_op = OP_SRL;  is_shift = 1'b1; end
          default: dec_op = OP_ILLEGAL;
        endcase
      end
      6'h08: begin dec_op = OP_ADDI;  is_itype = 1'b1; end
      6'h09: begin dec_op = OP_ADDIU; is_itype = 1'b1; end
      6'h0A: begin dec_op = OP_SLTI;  is_itype = 1'b1; end
      6'h0C: begin dec_op = OP_ANDI;  is_itype = 1'b1; end
      6'h0D: begin dec_op = OP_ORI;   is_itype = 1'b1; end
      default: dec_op = OP_ILLEGAL;
    endcase
  end

  // Register routing; shifts carry their single source (rt) on the A port.
  always_comb begin
    dec_rs  = 5'd0;
    dec_rt  = 5'd0;
    dec_dst = 5'd0;
    reads_a = 1'b0;
    reads_b = 1'b0;
    if (is_rtype) begin
      dec_rs  = f_rs;
      dec_rt  = f_rt;
      dec_dst = f_rd;
      reads_a = 1'b1;
      reads_b = 1'b1;
    end else if (is_shift) begin
      dec_rs  = f_rt;
      dec_dst = f_rd;
      reads_a = 1'b1;
    end else if (is_itype) begin
      dec_rs  = f_rs;
      dec_dst = f_rt;
      reads_a = 1'b1;
    end
  end

  assign dec_illegal = (dec_op == OP_ILLEGAL);
  assign dec_wen     = !dec_illegal;

  logic [31:0] busy;
  logic [31:0] busy_next;
  logic        hazard;
  logic        accept;

  // Busy bits are looked up registered only: a writeback unblocks next cycle.
  assign hazard   = (reads_a && busy[dec_rs]) || (reads_b && busy[dec_rt]);
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Clear first, then set, so an issue to the same register wins.
  always_comb begin
    busy_next = busy;
    if (wb_valid && (wb_addr != 5'd0)) begin
      busy_next[wb_addr] = 1'b0;
    end
    if (accept && dec_wen && (dec_dst != 5'd0)) begin
      busy_next[dec_dst] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_alu_op  <= 4'd0;
      out_rs      <= 5'd0;
      out_rt      <= 5'd0;
      out_dst     <= 5'd0;
      out_wen     <= 1'b0;
      out_imm     <= 16'd0;
      out_sa      <= 16'd0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_alu_op  <= dec_op;
      out_rs      <= dec_rs;
      out_rt      <= dec_rt;
      out_dst     <= dec_dst;
      out_wen     <= dec_wen;
      out_imm     <= in_instr[15:0];
      out_sa      <= {11'b0, in_instr[10:6]};
      out_illegal <= dec_illegal;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // NOTE: the busy array is only 32 flops and must be empty after reset for
  // hazard detection to be correct, so unlike a RAM it is reset explicitly.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_count <= '0;
      stall_count <= '0;
    end else begin
      if (accept && (issue_count != {CNT_W{1'b1}})) begin
        issue_count <= issue_count + CNT_W'(1);
      end
      if (in_valid && hazard && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mips_decode_issue.sv
// Directed bench for mips_decode_issue: decode fields, RAW stalls, slot
// backpressure, $0 handling, set-wins-over-writeback and mid-run reset.
module tb_mips_decode_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_dst;
  logic        out_wen;
  logic [15:0] out_imm;
  logic [15:0] out_sa;
  logic        out_illegal;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [15:0] stall_count;
  logic [15:0] issue_count;

  int checks   = 0;
  int failures = 0;

  mips_decode_issue #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_rs(out_rs), .out_rt(out_rt), .out_dst(out_dst),
    .out_wen(out_wen), .out_imm(out_imm), .out_sa(out_sa), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .stall_count(stall_count), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_addr = 5'd0;
    step(); step();
    rst = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
    checks++; if (out_alu_op !== 4'd0) begin failures++; $display("FAIL rst_alu_op got=%0d exp=0", out_alu_op); end
    checks++; if (out_imm !== 16'd0) begin failures++; $display("FAIL rst_imm got=%0h exp=0", out_imm); end
    checks++; if (issue_count !== 16'd0) begin failures++; $display("FAIL rst_issue got=%0d exp=0", issue_count); end
    checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL rst_stall got=%0d exp=0", stall_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
  endtask

  task automatic test_add();
    in_instr = 32'h00221820; in_valid = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL add_ready got=%0h exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0h exp=1", out_valid); end
    checks++; if (out_alu_op !== 4'd0) begin failures++; $display("FAIL add_op got=%0d exp=0", out_alu_op); end
    checks++; if (out_rs !== 5'd1) begin failures++; $display("FAIL add_rs got=%0d exp=1", out_rs); end
    checks++; if (out_rt !== 5'd2) begin failures++; $display("FAIL add_rt got=%0d exp=2", out_rt); end
    checks++; if (out_dst !== 5'd3) begin failures++; $display("FAIL add_dst got=%0d exp=3", out_dst); end
    checks++; if (out_wen !== 1'b1) begin failures++; $display("FAIL add_wen got=%0h exp=1", out_wen); end
    checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL add_illegal got=%0h exp=0", out_illegal); end
    checks++; if (issue_count !== 16'd1) begin failures++; $display("FAIL add_issue got=%0d exp=1", issue_count); end
  endtask

  task automatic test_raw_stall();
    in_instr = 32'h2065FFFF; in_valid = 1'b1; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_ready0 got=%0h exp=0", in_ready); end
    step();
    checks++; if (stall_count !== 16'd1) begin failures++; $display("FAIL raw_stall1 got=%0d exp=1", stall_count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL raw_drain got=%0h exp=0", out_valid); end
    step();
    checks++; if (stall_count !== 16'd2) begin failures++; $display("FAIL raw_stall2 got=%0d exp=2", stall_count); end
    wb_valid = 1'b1; wb_addr = 5'd3; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_no_bypass got=%0h exp=0", in_ready); end
    step();
    wb_valid = 1'b0; wb_addr = 5'd0; #1;
    checks++; if (stall_count !== 16'd3) begin failures++; $display("FAIL raw_stall3 got=%0d exp=3", stall_count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_unblock got=%0h exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%0h exp=1", out_valid); end
    checks++; if (out_alu_op !== 4'd1) begin failures++; $display("FAIL addi_op got=%0d exp=1", out_alu_op); end
    checks++; if (out_rs !== 5'd3) begin failures++; $display("FAIL addi_rs got=%0d exp=3", out_rs); end
    checks++; if (out_dst !== 5'd5) begin failures++; $display("FAIL addi_dst got=%0d exp=5", out_dst); end
    checks++; if (out_imm !== 16'hFFFF) begin failures++; $display("FAIL addi_imm got=%0h exp=ffff", out_imm); end
    checks++; if (issue_count !== 16'd2) begin failures++; $display("FAIL addi_issue got=%0d exp=2", issue_count); end
    checks++; if (stall_count !== 16'd3) begin failures++; $display("FAIL addi_stall got=%0d exp=3", stall_count); end
  endtask

  task automatic test_sll();
    in_instr = 32'h00022140; in_valid = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL sll_ready got=%0h exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_alu_op !== 4'd10) begin failures++; $display("FAIL sll_op got=%0d exp=10", out_alu_op); end
    checks++; if (out_rs !== 5'd2) begin failures++; $display("FAIL sll_rs got=%0d exp=2", out_rs); end
    checks++; if (out_rt !== 5'd0) begin failures++; $display("FAIL sll_rt got=%0d exp=0", out_rt); end
    checks++; if (out_dst !== 5'd4) begin failures++; $display("FAIL sll_dst got=%0d exp=4", out_dst); end
    checks++; if (out_sa !== 16'h0005) begin failures++; $display("FAIL sll_sa got=%0h exp=5", out_sa); end
    checks++; if (issue_count !== 16'd3) begin failures++; $display("FAIL sll_issue got=%0d exp=3", issue_count); end
  endtask

  task automatic test_illegal();
    in_instr = 32'hFC000000; in_valid = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ill_ready got=%0h exp=1", in_ready); end
    step();
    checks++; if (out_illegal !== 1'b1) begin failures++; $display("FAIL ill_flag got=%0h exp=1", out_illegal); end
    checks++; if (out_alu_op !== 4'd15) begin failures++; $display("FAIL ill_op got=%0d exp=15", out_alu_op); end
    checks++; if (out_wen !== 1'b0) begin failures++; $display("FAIL ill_wen got=%0h exp=0", out_wen); end
    checks++; if (issue_count !== 16'd4) begin failures++; $display("FAIL ill_issue got=%0d exp=4", issue_count); end
    // Illegal word with rt=rd=$10 must leave $10 free.
    in_instr = 32'hFC0A5000;
    step();
    in_instr = 32'h21490001; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ill_no_busy got=%0h exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_alu_op !== 4'd1) begin failures++; $display("FAIL ill_next_op got=%0d exp=1", out_alu_op); end
    checks++; if (issue_count !== 16'd6) begin failures++; $display("FAIL ill_next_issue got=%0d exp=6", issue_count); end
  endtask

  task automatic test_back_to_back();
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0h exp=0", out_valid); end
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00223020;
    step();
    in_instr = 32'h34271234;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%0h exp=1", i, out_valid); end
      checks++; if ({out_alu_op, out_rs, out_rt, out_dst} !== {4'd0, 5'd1, 5'd2, 5'd6}) begin failures++; $display("FAIL bp_hold[%0d] got=%0h exp=%0h", i, {out_alu_op, out_rs, out_rt, out_dst}, {4'd0, 5'd1, 5'd2, 5'd6}); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready[%0d] got=%0h exp=0", i, in_ready); end
    end
    checks++; if (stall_count !== 16'd3) begin failures++; $display("FAIL bp_no_stall got=%0d exp=3", stall_count); end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%0h exp=1", in_ready); end
    step();
    checks++; if ({out_alu_op, out_dst, out_imm} !== {4'd9, 5'd7, 16'h1234}) begin failures++; $display("FAIL b2b_ori got=%0h exp=%0h", {out_alu_op, out_dst, out_imm}, {4'd9, 5'd7, 16'h1234}); end
    in_instr = 32'h00224024;
    step();
    checks++; if ({out_valid, out_alu_op, out_dst} !== {1'b1, 4'd6, 5'd8}) begin failures++; $display("FAIL b2b_and got=%0h exp=%0h", {out_valid, out_alu_op, out_dst}, {1'b1, 4'd6, 5'd8}); end
    in_instr = 32'h00225022;
    step();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_alu_op, out_dst} !== {1'b1, 4'd4, 5'd10}) begin failures++; $display("FAIL b2b_sub got=%0h exp=%0h", {out_valid, out_alu_op, out_dst}, {1'b1, 4'd4, 5'd10}); end
    checks++; if (issue_count !== 16'd10) begin failures++; $display("FAIL b2b_issue got=%0d exp=10", issue_count); end
  endtask

  task automatic test_zero_reg();
    in_instr = 32'h00220020; in_valid = 1'b1;
    step();
    checks++; if ({out_dst, out_wen} !== {5'd0, 1'b1}) begin failures++; $display("FAIL zero_add got=%0h exp=%0h", {out_dst, out_wen}, {5'd0, 1'b1}); end
    in_instr = 32'h200B0001; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL zero_no_stall got=%0h exp=1", in_ready); end
    step();
    checks++; if ({out_alu_op, out_rs, out_dst} !== {4'd1, 5'd0, 5'd11}) begin failures++; $display("FAIL zero_addi got=%0h exp=%0h", {out_alu_op, out_rs, out_dst}, {4'd1, 5'd0, 5'd11}); end
    // Reissue to $11 while $11 writes back: the new set must win.
    in_instr = 32'h200B0003; wb_valid = 1'b1; wb_addr = 5'd11;
    step();
    wb_valid = 1'b0; wb_addr = 5'd0;
    in_instr = 32'h216D0000; #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL set_wins got=%0h exp=0", in_ready); end
    checks++; if (issue_count !== 16'd13) begin failures++; $display("FAIL zero_issue got=%0d exp=13", issue_count); end
  endtask

  task automatic test_reset_mid();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%0h exp=1", out_valid); end
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0h exp=0", out_valid); end
    checks++; if ({out_alu_op, out_dst, out_imm} !== 25'd0) begin failures++; $display("FAIL mid_fields got=%0h exp=0", {out_alu_op, out_dst, out_imm}); end
    checks++; if (issue_count !== 16'd0) begin failures++; $display("FAIL mid_issue got=%0d exp=0", issue_count); end
    checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL mid_stall got=%0d exp=0", stall_count); end
    in_valid = 1'b1; in_instr = 32'h216D0000; #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_busy_clear got=%0h exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if ({out_valid, out_rs, out_dst} !== {1'b1, 5'd11, 5'd13}) begin failures++; $display("FAIL mid_reissue got=%0h exp=%0h", {out_valid, out_rs, out_dst}, {1'b1, 5'd11, 5'd13}); end
    checks++; if (issue_count !== 16'd1) begin failures++; $display("FAIL mid_issue1 got=%0d exp=1", issue_count); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_raw_stall();
    test_sll();
    test_illegal();
    test_back_to_back();
    test_zero_reg();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
